// File: rtl/turbo_enc4.sv
// turbo_enc4 -- 4-lane parallel-concatenated turbo encoder.
// Buffers one frame of FRAME_LEN information bits, then streams four lanes per
// beat of systematic bit, RSC1 parity and RSC2 parity (RSC2 sees the frame
// through a linear-congruential interleaver j = (IL_OFF + i*IL_P) mod FRAME_LEN).
// Optional trellis termination beat: define TURBO_ENC_TERM_EN.
module turbo_enc4 #(
    parameter int FRAME_LEN = 64,   // power of two, multiple of 4, 8..1024
    parameter int IL_P      = 13,   // interleaver multiplier, odd
    parameter int IL_OFF    = 0     // interleaver offset
) (
    input  logic       clk,
    input  logic       rst,         // asynchronous, active-low
    input  logic       din_valid,
    input  logic [3:0] din,
    output logic       din_ready,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [3:0] x_o,
    output logic [3:0] y1_o,
    output logic [3:0] y2_o,
    output logic       dout_last,
    output logic       dout_tail
);

    localparam int AW  = $clog2(FRAME_LEN);   // bit address width
    localparam int QB  = FRAME_LEN / 4;       // beats per frame
    localparam int BW  = AW - 2;              // beat index width
    localparam int BCW = BW + 1;              // beat counter must reach QB

    localparam logic [AW-1:0]  IB_INIT   = AW'(IL_OFF % FRAME_LEN);
    localparam logic [AW-1:0]  P_MOD     = AW'(IL_P % FRAME_LEN);
    localparam logic [AW-1:0]  IB_STEP   = AW'((4 * IL_P) % FRAME_LEN);
    localparam logic [BCW-1:0] BC_LASTLD = BCW'(QB - 1);
    localparam logic [BCW-1:0] BC_DONE   = BCW'(QB);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(QB - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ENC
`ifdef TURBO_ENC_TERM_EN
        , S_TAIL
`endif
    } state_t;

    // Two-register recursive systematic convolutional encoder state.
    typedef struct packed {
        logic s1;
        logic s2;
    } rsc_t;

    state_t            state_q, state_d;
    logic [FRAME_LEN-1:0] frame_q, frame_view;
    // In ENC these registers describe the beat *after* the one on the outputs:
    // bc_q is the next beat to encode, ib_q its interleaver base, r1_q/r2_q the
    // encoder states after the beat currently presented.
    logic [BCW-1:0]    bc_q;
    logic [AW-1:0]     ib_q;
    rsc_t              r1_q, r2_q;

    logic              in_enc;
    logic [BW-1:0]     enc_beat;
    logic [AW-1:0]     enc_ib;
    rsc_t              enc_r1, enc_r2;
    logic [AW-1:0]     j_c [4];
    logic [3:0]        u_c, v_c, y1_c, y2_c;
    rsc_t              r1_end, r2_end;

    logic              load_fire, last_load, out_fire, enc_next, frame_end;

    assign din_ready = (state_q == S_LOAD);
    assign in_enc    = (state_q == S_ENC);
    assign load_fire = din_ready && din_valid;
    assign last_load = load_fire && (bc_q == BC_LASTLD);
    assign out_fire  = dout_valid && dout_ready;
    assign enc_next  = in_enc && out_fire && (bc_q != BC_DONE);
    assign frame_end = in_enc && out_fire && (bc_q == BC_DONE);

    // The first beat is encoded on the same edge that stores the last input
    // beat, so the encoder reads the buffer with the incoming beat merged in.
    assign enc_beat = in_enc ? bc_q[BW-1:0] : '0;
    assign enc_ib   = in_enc ? ib_q : IB_INIT;
    assign enc_r1   = in_enc ? r1_q : '0;
    assign enc_r2   = in_enc ? r2_q : '0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) state_q <= S_LOAD;
        else      state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            S_LOAD: if (last_load) state_d = S_ENC;
`ifdef TURBO_ENC_TERM_EN
            S_ENC:  if (frame_end) state_d = S_TAIL;
            S_TAIL: if (out_fire)  state_d = S_LOAD;
`else
            S_ENC:  if (frame_end) state_d = S_LOAD;
`endif
            default: state_d = S_LOAD;
        endcase
    end

    // Buffer view with the beat currently on din merged at its slot.
    always_comb begin
        frame_view = frame_q;
        if (state_q == S_LOAD) frame_view[{bc_q[BW-1:0], 2'b00} +: 4] = din;
    end

    // Frame buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is not reset; every bit is rewritten before a frame
        // is encoded, and a reset leaves no path that reads stale contents.
        if (load_fire) frame_q <= frame_view;
    end

    // Gather systematic and interleaved bits for the four lanes.
    always_comb begin
        u_c = '0;
        v_c = '0;
        for (int l = 0; l < 4; l++) begin
            j_c[l]  = enc_ib + AW'(l) * P_MOD;     // wraps mod FRAME_LEN
            u_c[l]  = frame_view[{enc_beat, 2'(l)}];
            v_c[l]  = frame_view[j_c[l]];
        end
    end

    // Both RSC encoders, four steps chained within one beat.
    always_comb begin
        // NOTE: blocking assignments here are deliberate: each lane must see
        // the state produced by the previous lane in the same evaluation.
        r1_end = enc_r1;
        r2_end = enc_r2;
        y1_c   = '0;
        y2_c   = '0;
        for (int l = 0; l < 4; l++) begin
            // a = u^s1^s2; parity = a^s2 = u^s1; next (s1,s2) = (a,s1)
            y1_c[l] = u_c[l] ^ r1_end.s1;
            r1_end  = '{s1: u_c[l] ^ r1_end.s1 ^ r1_end.s2, s2: r1_end.s1};
            y2_c[l] = v_c[l] ^ r2_end.s1;
            r2_end  = '{s1: v_c[l] ^ r2_end.s1 ^ r2_end.s2, s2: r2_end.s1};
        end
    end

    // Counters, encoder states and registered output beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc_q       <= '0;
            ib_q       <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            dout_valid <= 1'b0;
            x_o        <= '0;
            y1_o       <= '0;
            y2_o       <= '0;
            dout_last  <= 1'b0;
`ifdef TURBO_ENC_TERM_EN
            dout_tail  <= 1'b0;
`endif
        end else if (last_load || enc_next) begin
            bc_q       <= BCW'(enc_beat) + BCW'(1);
            ib_q       <= enc_ib + IB_STEP;
            r1_q       <= r1_end;
            r2_q       <= r2_end;
            dout_valid <= 1'b1;
            x_o        <= u_c;
            y1_o       <= y1_c;
            y2_o       <= y2_c;
`ifdef TURBO_ENC_TERM_EN
            dout_last  <= 1'b0;
`else
            dout_last  <= (enc_beat == LAST_BEAT);
`endif
        end else if (load_fire) begin
            bc_q <= bc_q + BCW'(1);
`ifdef TURBO_ENC_TERM_EN
        end else if (frame_end) begin
            // Two tail steps per encoder: u = s1^s2, parity = s2, then the
            // state shifts to (0, s1), so the second step gives u = parity = s1.
            bc_q       <= '0;
            x_o        <= {r2_q.s1, r2_q.s1 ^ r2_q.s2, r1_q.s1, r1_q.s1 ^ r1_q.s2};
            y1_o       <= {2'b00, r1_q.s1, r1_q.s2};
            y2_o       <= {r2_q.s1, r2_q.s2, 2'b00};
            dout_last  <= 1'b1;
            dout_tail  <= 1'b1;
        end else if ((state_q == S_TAIL) && out_fire) begin
            dout_valid <= 1'b0;
            x_o        <= '0;
            y1_o       <= '0;
            y2_o       <= '0;
            dout_last  <= 1'b0;
            dout_tail  <= 1'b0;
`else
        end else if (frame_end) begin
            bc_q       <= '0;
            dout_valid <= 1'b0;
            x_o        <= '0;
            y1_o       <= '0;
            y2_o       <= '0;
            dout_last  <= 1'b0;
`endif
        end
    end

`ifndef TURBO_ENC_TERM_EN
    assign dout_tail = 1'b0;
`endif

endmodule
